// File: rtl/coin_return_fsm.sv
// coin_return_fsm: returns change as a greedy sequence of 10/5/2/1 coins over a
// 4-phase coin_req/coin_ack handshake, with an ack timeout that raises a sticky fault.
module coin_return_fsm #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] amount,
    input  logic       coin_ack,
    output logic       coin_req,
    output logic [2:0] coin_code,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [4:0] remaining
);
    typedef enum logic [2:0] {IDLE, SELECT, EJECT, RELEASE, DONE, FAULT} state_t;

    state_t     state_q, state_d;
    logic [4:0] rem_q, rem_d;
    logic [2:0] code_q, code_d;
    logic [7:0] cnt_q, cnt_d;
    logic       fault_q, fault_d;
    logic       armed_q, armed_d;
    logic       req_q, req_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [2:0] sel;
    logic [4:0] val;

    assign sel = rem_q >= 5'd10 ? 3'b100 : rem_q >= 5'd5 ? 3'b011 : rem_q >= 5'd2 ? 3'b010 : 3'b001;
    assign val = code_q == 3'b100 ? 5'd10 : code_q == 3'b011 ? 5'd5 :
                 code_q == 3'b010 ? 5'd2  : code_q == 3'b001 ? 5'd1 : 5'd0;

    // armed means a low ack has been seen since the last credited coin
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        armed_d = coin_ack ? armed_q : 1'b1;
        case (state_q)
            IDLE: if (start) begin
                state_d = SELECT;
                rem_d   = amount;
                fault_d = 1'b0;
            end
            SELECT: begin
                if (rem_q == 5'd0) state_d = DONE;
                else begin
                    state_d = EJECT;
                    code_d  = sel;
                    cnt_d   = 8'd0;
                end
            end
            EJECT: begin
                if (coin_ack && armed_q) begin
                    state_d = RELEASE;
                    rem_d   = rem_q >= val ? rem_q - val : 5'd0;
                    code_d  = 3'b000;
                    cnt_d   = 8'd0;
                    armed_d = 1'b0;
                end else if (cnt_q == 8'(ACK_TIMEOUT - 1)) begin
                    state_d = FAULT;
                    code_d  = 3'b000;
                    cnt_d   = 8'd0;
                    fault_d = 1'b1;
                end else cnt_d = cnt_q + 8'd1;
            end
            RELEASE: if (!coin_ack) state_d = SELECT;
            DONE:    state_d = IDLE;
            FAULT:   if (!coin_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        req_d  = state_d == EJECT;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= 5'd0;
            code_q  <= 3'b000;
            cnt_q   <= 8'd0;
            fault_q <= 1'b0;
            armed_q <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            armed_q <= armed_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign coin_req  = req_q;
    assign coin_code = code_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign remaining = rem_q;
endmodule

// File: doc/coin_return_fsm.md
COIN_RETURN_FSM -- requirements
Module: coin_return_fsm

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16: cycles to wait for coin_ack before declaring a fault; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to return the change in amount; sampled only in IDLE.
REQ-005 amount  input  5  change owed, in base units (0..31); captured on an accepted start.
REQ-006 coin_ack  input  1  level from the ejector; high means the requested coin has been dropped.
REQ-007 coin_req  output  1  high while a coin ejection is requested.
REQ-008 coin_code  output  3  coin to eject: 3'b100 = 10 units, 3'b011 = 5, 3'b010 = 2, 3'b001 = 1; 3'b000 when coin_req is low.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when the full amount has been returned.
REQ-011 fault  output  1  sticky high after an ack timeout, until the next accepted start or reset.
REQ-012 remaining  output  5  units still to be returned.

Function
REQ-013 States: IDLE, SELECT, EJECT, RELEASE, DONE, FAULT; encoded in 3 bits.
REQ-014 IDLE: on start=1, load remaining<=amount, clear fault, go to SELECT; start in any other state is ignored.
REQ-015 SELECT: remaining=0 -> DONE; otherwise choose the largest coin not exceeding remaining (>=10 -> 100, >=5 -> 011, >=2 -> 010, else 001), latch coin_code, go to EJECT.
REQ-016 EJECT: coin_req=1 and coin_code is held stable; the timeout counter increments each cycle.
REQ-017 EJECT with coin_ack=1: subtract the coin value from remaining, drop coin_req, clear the counter, go to RELEASE; the subtraction never underflows.
REQ-018 EJECT with no ack after ACK_TIMEOUT cycles: drop coin_req, go to FAULT; remaining is unchanged.
REQ-019 RELEASE: wait for coin_ack=0 (4-phase handshake), then go to SELECT; coin_req stays low.
REQ-020 A coin_ack that is already high on entry to EJECT counts only after a low has been seen in RELEASE; a new coin is never credited on a stale ack.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE.
REQ-022 FAULT: fault=1 and busy=1; go to IDLE once coin_ack=0; fault stays high in IDLE.
REQ-023 Request-to-request latency: SELECT to coin_req high takes 1 cycle; a coin costs at least 4 cycles (SELECT, EJECT, ack, RELEASE).
REQ-024 start with amount=0: IDLE -> SELECT -> DONE, done pulses 2 cycles after start, and coin_req never rises.
REQ-025 All outputs are registered; the block produces no combinational path from an input to an output.

Reset
REQ-026 When reset=0 the block SHALL immediately enter IDLE, clear coin_req, coin_code, busy, done, fault, remaining and the timeout counter to 0, with no clock edge required.
REQ-027 When reset is asserted in the middle of an ejection, coin_req SHALL drop asynchronously, and the unreturned remainder SHALL be discarded without any report.
REQ-028 The first accepted start SHALL occur no earlier than the first rising clk edge after reset returns to 1.

Verification
REQ-029 amount=18, ack returned 2 cycles after each coin_req -> coin codes 100, 011, 010, 001 in that order, remaining 18->8->3->1->0, one done pulse, fault=0.
REQ-030 amount=0 -> done pulses 2 cycles after start, coin_req stays 0, and busy is high for exactly 2 cycles.
REQ-031 amount=7 with ack never returned -> coin_req high for ACK_TIMEOUT cycles, then fault=1, remaining=7, no done pulse; the next start clears fault.
REQ-032 coin_ack held high across two coins -> the second coin is not credited until ack falls and rises again, and remaining decrements once per ack rising edge.
REQ-033 reset driven low mid-EJECT with amount=31 -> coin_req, busy and remaining all 0 in the same cycle; after reset is released, a start with amount=4 returns 010, 010.
REQ-034 start pulsed while busy=1 -> ignored, and the sequence of the original amount completes unchanged.
